// File: rtl/ir_pkg.sv
// Shared types and constants for the IR sensor interface.
// The ambient-subtraction states exist only when IR_AMBIENT_SUB_EN is defined.
package ir_pkg;

  localparam int NUM_CH_DEF = 8;
  localparam int RES_W_DEF  = 12;
  localparam int CH_W       = 3;

  typedef enum logic [2:0] {
    IDLE,
    SETTLE,
    CONV,
    WAIT,
    DONE
`ifdef IR_AMBIENT_SUB_EN
    ,
    AMB_CONV,
    AMB_WAIT
`endif
  } state_t;

endpackage

// File: rtl/ir_sensor_intf_if.sv
// A2D conversion handshake between the IR sequencer (master) and the A2D interface (slave).
// strt_cnv is a one-cycle request with chnnl valid; at most one conversion is outstanding,
// and cnv_cmplt is a one-cycle done strobe with res valid in that same cycle.
interface ir_sensor_intf_if #(
  parameter int RES_W = 12
);

  logic                      strt_cnv;
  logic [ir_pkg::CH_W-1:0]   chnnl;
  logic                      cnv_cmplt;
  logic [RES_W-1:0]          res;

  modport master (output strt_cnv, output chnnl, input cnv_cmplt, input res);
  modport slave  (input strt_cnv, input chnnl, output cnv_cmplt, output res);

endinterface

// File: rtl/ir_tmr.sv
// Free-running sweep-period timer with terminal-count flag, plus a loadable
// settle down-counter whose done flag is high once it reaches zero.
module ir_tmr #(
  parameter int PERIOD_W   = 17,
  parameter int SETTLE_CYC = 4096
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  output logic tc,
  output logic settle_done
);

  localparam int SW = $clog2(SETTLE_CYC + 1);

  logic [PERIOD_W-1:0] period;
  logic [SW-1:0]       settle;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      period <= '0;
      settle <= '0;
    end else begin
      period <= period + PERIOD_W'(1);
      // Loading SETTLE_CYC-1 makes done true on the SETTLE_CYC-th clock after the load.
      if (load)
        settle <= SW'(SETTLE_CYC - 1);
      else if (settle != '0)
        settle <= settle - SW'(1);
    end
  end

  assign tc          = &period;
  assign settle_done = (settle == '0);

endmodule

// File: rtl/ir_sensor_intf.sv
// IR sensor sweep sequencer: fires the emitters, converts all channels, stores readings.
// Define IR_AMBIENT_SUB_EN to add a dark (ambient) pass that is subtracted from the lit pass.
module ir_sensor_intf
  import ir_pkg::*;
#(
  parameter int PERIOD_W   = 17,
  parameter int SETTLE_CYC = 4096,
  parameter int NUM_CH     = NUM_CH_DEF,
  parameter int RES_W      = RES_W_DEF
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  output logic                    IR_en,
  ir_sensor_intf_if.master        a2d,
  output logic                    IR_vld,
  input  logic [CH_W-1:0]         rd_sel,
  output logic [RES_W-1:0]        rd_data,
  output logic [NUM_CH*RES_W-1:0] ir_all,
  output state_t                  fsm_state
);

  localparam logic [CH_W-1:0] LAST = CH_W'(NUM_CH - 1);

  state_t            state, nxt;
  logic [CH_W-1:0]   idx;
  logic              tc, settle_done, settle_load;
  logic              idx_clr, idx_inc, store_lit;
  logic [RES_W-1:0]  rdg [NUM_CH];
  logic [RES_W-1:0]  lit_val;

  ir_tmr #(.PERIOD_W(PERIOD_W), .SETTLE_CYC(SETTLE_CYC)) u_tmr (
    .clk         (clk),
    .rst_n       (rst_n),
    .load        (settle_load),
    .tc          (tc),
    .settle_done (settle_done)
  );

`ifdef IR_AMBIENT_SUB_EN
  logic              store_amb;
  logic [RES_W-1:0]  amb [NUM_CH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NUM_CH; k++) amb[k] <= '0;
    end else if (store_amb) begin
      amb[idx] <= a2d.res;
    end
  end

  // Lit minus dark, clamped at zero so a brighter ambient never wraps.
  assign lit_val = (a2d.res > amb[idx]) ? (a2d.res - amb[idx]) : '0;
`else
  assign lit_val = a2d.res;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= nxt;
  end

  always_comb begin
    nxt          = state;
    IR_en        = 1'b0;
    a2d.strt_cnv = 1'b0;
    IR_vld       = 1'b0;
    settle_load  = 1'b0;
    idx_clr      = 1'b0;
    idx_inc      = 1'b0;
    store_lit    = 1'b0;
`ifdef IR_AMBIENT_SUB_EN
    store_amb    = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (en && tc) begin
          idx_clr = 1'b1;
`ifdef IR_AMBIENT_SUB_EN
          nxt = AMB_CONV;
`else
          nxt         = SETTLE;
          settle_load = 1'b1;
`endif
        end
      end
`ifdef IR_AMBIENT_SUB_EN
      AMB_CONV: begin
        a2d.strt_cnv = 1'b1;
        nxt          = AMB_WAIT;
      end
      AMB_WAIT: begin
        if (a2d.cnv_cmplt) begin
          store_amb = 1'b1;
          if (idx == LAST) begin
            nxt         = SETTLE;
            settle_load = 1'b1;
            idx_clr     = 1'b1;
          end else begin
            idx_inc = 1'b1;
            nxt     = AMB_CONV;
          end
        end
      end
`endif
      SETTLE: begin
        IR_en = 1'b1;
        if (settle_done) nxt = CONV;
      end
      CONV: begin
        IR_en        = 1'b1;
        a2d.strt_cnv = 1'b1;
        nxt          = WAIT;
      end
      WAIT: begin
        IR_en = 1'b1;
        if (a2d.cnv_cmplt) begin
          store_lit = 1'b1;
          if (idx == LAST) begin
            nxt = DONE;
          end else begin
            idx_inc = 1'b1;
            nxt     = CONV;
          end
        end
      end
      DONE: begin
        IR_vld = 1'b1;
        nxt    = IDLE;
      end
      default: nxt = IDLE;
    endcase
    // Dropping en abandons the sweep; anything already stored is kept.
    if (state != IDLE && !en) nxt = IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       idx <= '0;
    else if (idx_clr) idx <= '0;
    else if (idx_inc) idx <= idx + CH_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NUM_CH; k++) rdg[k] <= '0;
    end else if (store_lit) begin
      rdg[idx] <= lit_val;
    end
  end

  always_comb begin
    rd_data = '0;
    if (int'(rd_sel) < NUM_CH) rd_data = rdg[rd_sel];
  end

  for (genvar k = 0; k < NUM_CH; k++) begin : g_flat
    assign ir_all[k*RES_W +: RES_W] = rdg[k];
  end

  assign a2d.chnnl = idx;
  assign fsm_state = state;

endmodule

// File: tb/tb_ir_sensor_intf.sv
// Directed bench for ir_sensor_intf with a 5-clock A2D model (res = base + chnnl).
// Ambient-subtraction checks are compiled in when IR_AMBIENT_SUB_EN is defined.
module tb_ir_sensor_intf;
  import ir_pkg::*;

  localparam int PW  = 8;
  localparam int SC  = 16;
  localparam int NC  = 8;
  localparam int RW  = 12;
  localparam int LAT = 5;
`ifdef IR_AMBIENT_SUB_EN
  localparam int AMB_CYC = NC * (1 + LAT);
  localparam int PASSES  = 2;
`else
  localparam int AMB_CYC = 0;
  localparam int PASSES  = 1;
`endif
  // Timer hits all-ones after 255 clocks; the sweep leaves IDLE on clock 256.
  localparam int EN_RISE   = 256 + AMB_CYC;
  localparam int FIRST_STR = EN_RISE + SC;
  localparam int VLD_CYC   = FIRST_STR + NC * (1 + LAT);

  logic clk, rst_n, en;
  logic IR_en, IR_vld;
  logic [2:0] rd_sel;
  logic [RW-1:0] rd_data;
  logic [NC*RW-1:0] ir_all;
  state_t fsm_state;

  ir_sensor_intf_if #(.RES_W(RW)) a2d ();

  ir_sensor_intf #(.PERIOD_W(PW), .SETTLE_CYC(SC), .NUM_CH(NC), .RES_W(RW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .IR_en     (IR_en),
    .a2d       (a2d),
    .IR_vld    (IR_vld),
    .rd_sel    (rd_sel),
    .rd_data   (rd_data),
    .ir_all    (ir_all),
    .fsm_state (fsm_state)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int cyc;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ---------------- A2D model ----------------
  logic          m_cmplt, spur, ch_add, pend;
  logic [RW-1:0] m_res, spur_res, lit_base, amb_base, m_val;
  int            m_cnt;

  assign a2d.cnv_cmplt = m_cmplt | spur;
  assign a2d.res       = spur ? spur_res : m_res;

  always @(negedge clk) begin
    m_cmplt = 1'b0;
    if (!rst_n) begin
      pend = 1'b0;
    end else begin
      if (pend) begin
        m_cnt--;
        if (m_cnt == 0) begin
          m_cmplt = 1'b1;
          m_res   = m_val;
          pend    = 1'b0;
        end
      end
      if (a2d.strt_cnv) begin
        pend  = 1'b1;
        m_cnt = LAT;
        m_val = IR_en ? (lit_base + (ch_add ? RW'(a2d.chnnl) : RW'(0))) : amb_base;
      end
    end
  end

  // ---------------- monitor ----------------
  int strt_cnt, dbl_strt, lit_strt, dark_strt, ir_en_cnt, vld_cnt;
  int first_en, first_lit_strt;
  logic prev_strt, prev_en;
  logic [2:0] ch_q[$];
  int vld_q[$];

  task automatic reset_counters();
    strt_cnt = 0; dbl_strt = 0; lit_strt = 0; dark_strt = 0;
    ir_en_cnt = 0; vld_cnt = 0; first_en = -1; first_lit_strt = -1;
    prev_strt = 1'b0; prev_en = 1'b0;
    ch_q.delete(); vld_q.delete();
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (a2d.strt_cnv) begin
        strt_cnt++;
        if (prev_strt) dbl_strt++;
        if (IR_en) begin
          lit_strt++;
          ch_q.push_back(a2d.chnnl);
          if (first_lit_strt < 0) first_lit_strt = cyc;
        end else begin
          dark_strt++;
        end
      end
      prev_strt = a2d.strt_cnv;
      if (IR_en) ir_en_cnt++;
      if (IR_en && !prev_en && first_en < 0) first_en = cyc;
      prev_en = IR_en;
      if (IR_vld) begin
        vld_cnt++;
        vld_q.push_back(cyc);
      end
    end
  end

  // ---------------- scoreboard ----------------
  int errors, checks;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [RW-1:0] rdg(input int k);
    return ir_all[k*RW +: RW];
  endfunction

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_vld(input int maxc);
    int v0;
    bit ok;
    v0 = vld_cnt;
    ok = 1'b0;
    for (int i = 0; i < maxc; i++) begin
      tick();
      if (vld_cnt != v0) begin
        ok = 1'b1;
        break;
      end
    end
    chk("ir_vld_timeout", 32'(ok), 32'd1);
  endtask

  task automatic wait_lit_strt(input int maxc);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < maxc; i++) begin
      tick();
      if (a2d.strt_cnv && IR_en) begin
        ok = 1'b1;
        break;
      end
    end
    chk("strt_timeout", 32'(ok), 32'd1);
  endtask

  typedef struct {
    logic [2:0]    sel;
    logic [RW-1:0] exp;
  } vec_t;
  vec_t tbl[8];

  // ---------------- test ----------------
  initial begin
    errors = 0; checks = 0;
    reset_counters();
    rst_n = 1'b0; en = 1'b0; rd_sel = 3'd0;
    spur = 1'b0; spur_res = '0; ch_add = 1'b1;
    lit_base = 12'h100; amb_base = 12'h000;
    m_cmplt = 1'b0; m_res = '0; pend = 1'b0; m_cnt = 0; m_val = '0;

    tbl[0] = '{3'd3, 12'h103};
    tbl[1] = '{3'd0, 12'h100};
    tbl[2] = '{3'd7, 12'h107};
    tbl[3] = '{3'd1, 12'h101};
    tbl[4] = '{3'd5, 12'h105};
    tbl[5] = '{3'd2, 12'h102};
    tbl[6] = '{3'd6, 12'h106};
    tbl[7] = '{3'd4, 12'h104};

    #3;
    chk("rst_IR_en", 32'(IR_en), 32'd0);
    chk("rst_strt_cnv", 32'(a2d.strt_cnv), 32'd0);
    chk("rst_chnnl", 32'(a2d.chnnl), 32'd0);
    chk("rst_IR_vld", 32'(IR_vld), 32'd0);
    chk("rst_state", 32'(fsm_state), 32'(IDLE));
    for (int k = 0; k < NC; k++) chk("rst_reading", 32'(rdg(k)), 32'd0);

    @(negedge clk);
    rst_n = 1'b1;
    en = 1'b1;
    reset_counters();

    // Basic sweep
    wait_vld(400);
    chk("vld_cycle", 32'(vld_q[0]), 32'(VLD_CYC));
    chk("IR_en_rise", 32'(first_en), 32'(EN_RISE));
    chk("first_strt", 32'(first_lit_strt), 32'(FIRST_STR));
    chk("chnnl_count", 32'(ch_q.size()), 32'd8);
    for (int k = 0; k < NC; k++) chk("chnnl_step", 32'(ch_q[k]), 32'(k));
    for (int i = 0; i < 8; i++) begin
      rd_sel = tbl[i].sel;
      #1;
      chk("rd_data", 32'(rd_data), 32'(tbl[i].exp));
      chk("ir_all", 32'(rdg(int'(tbl[i].sel))), 32'(tbl[i].exp));
    end

    // Period: two more sweeps, 256 clocks apart
    wait_vld(300);
    wait_vld(300);
    repeat (50) tick();
    chk("vld_count", 32'(vld_cnt), 32'd3);
    chk("period_1", 32'(vld_q[1] - vld_q[0]), 32'd256);
    chk("period_2", 32'(vld_q[2] - vld_q[1]), 32'd256);
    chk("IR_en_clocks", 32'(ir_en_cnt), 32'd192);
    chk("strt_double", 32'(dbl_strt), 32'd0);
    chk("strt_count", 32'(strt_cnt), 32'(NC * 3 * PASSES));

    // Abort after third lit conversion
    lit_base = 12'h300;
    begin
      int n;
      bit ok;
      n = 0;
      ok = 1'b0;
      for (int i = 0; i < 1000; i++) begin
        tick();
        if (a2d.cnv_cmplt && IR_en) n++;
        if (n == 3) begin
          ok = 1'b1;
          break;
        end
      end
      chk("abort_wait", 32'(ok), 32'd1);
    end
    @(posedge clk);
    #1;
    en = 1'b0;
    @(posedge clk);
    #1;
    chk("abort_IR_en", 32'(IR_en), 32'd0);
    chk("abort_state", 32'(fsm_state), 32'(IDLE));
    repeat (100) tick();
    chk("abort_no_vld", 32'(vld_cnt), 32'd3);
    for (int k = 0; k < NC; k++)
      chk("abort_reading", 32'(rdg(k)), (k < 3) ? 32'(12'h300 + k) : 32'(12'h100 + k));

    en = 1'b1;
    wait_vld(600);
    for (int k = 0; k < NC; k++) chk("resweep_reading", 32'(rdg(k)), 32'(12'h300 + k));

    // Spurious strobe during SETTLE
    begin
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < 400; i++) begin
        tick();
        if (IR_en) begin
          ok = 1'b1;
          break;
        end
      end
      chk("settle_wait", 32'(ok), 32'd1);
    end
    repeat (3) tick();
    spur_res = 12'hABC;
    spur = 1'b1;
    tick();
    spur = 1'b0;
    chk("spur_state", 32'(fsm_state), 32'(SETTLE));
    for (int k = 0; k < NC; k++) chk("spur_reading", 32'(rdg(k)), 32'(12'h300 + k));

    // Asynchronous reset in WAIT
    wait_lit_strt(100);
    tick();
    chk("pre_rst_state", 32'(fsm_state), 32'(WAIT));
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_IR_en", 32'(IR_en), 32'd0);
    chk("arst_strt", 32'(a2d.strt_cnv), 32'd0);
    chk("arst_chnnl", 32'(a2d.chnnl), 32'd0);
    chk("arst_state", 32'(fsm_state), 32'(IDLE));
    for (int k = 0; k < NC; k++) chk("arst_reading", 32'(rdg(k)), 32'd0);
    lit_base = 12'h100;
    @(negedge clk);
    rst_n = 1'b1;
    reset_counters();
    wait_vld(400);
    chk("post_rst_en_rise", 32'(first_en), 32'(EN_RISE));
    chk("post_rst_vld", 32'(vld_q[0]), 32'(VLD_CYC));

`ifdef IR_AMBIENT_SUB_EN
    // Ambient subtraction
    ch_add = 1'b0;
    amb_base = 12'h040;
    dark_strt = 0;
    lit_strt = 0;
    wait_vld(400);
    chk("amb_dark_conv", 32'(dark_strt), 32'd8);
    chk("amb_lit_conv", 32'(lit_strt), 32'd8);
    for (int k = 0; k < NC; k++) chk("amb_reading", 32'(rdg(k)), 32'h0C0);
    amb_base = 12'h200;
    wait_vld(400);
    for (int k = 0; k < NC; k++) chk("amb_saturate", 32'(rdg(k)), 32'h000);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
